// File: rtl/syscall_service_pkg.sv
// Shared definitions for the syscall service responder.
// FSM encodings, service selection order and data widths.
package syscall_service_pkg;

  localparam int RES_W = 32;
  localparam int KB_W  = 8;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_RD_BMP     = 3'd1;
  localparam logic [2:0] S_WAIT_FLUSH = 3'd2;
  localparam logic [2:0] S_WAIT_COPY  = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  typedef enum logic [2:0] {
    SV_NONE,
    SV_FLUSH,
    SV_COPY,
    SV_BMP,
    SV_KB,
    SV_CYC,
    SV_SCR
  } svc_e;

  function automatic svc_e svc_pick(
    input logic flush,
    input logic copy,
    input logic bmp,
    input logic kb,
    input logic cyc,
    input logic scr
  );
    if (flush)     return SV_FLUSH;
    else if (copy) return SV_COPY;
    else if (bmp)  return SV_BMP;
    else if (kb)   return SV_KB;
    else if (cyc)  return SV_CYC;
    else if (scr)  return SV_SCR;
    else           return SV_NONE;
  endfunction

endpackage

// File: rtl/syscall_service_if.sv
// Bundle between the syscall decoder / peripherals and the
// service responder; slave is the responder side.
interface syscall_service_if
  import syscall_service_pkg::*;
#(
  parameter int BMP_AW = 10
) ();

  logic             Get_KB_in;
  logic             Get_Bitmap;
  logic             FrameFlush;
  logic             CopyToRAM;
  logic             Cycles;
  logic             Screen_opt;
  logic [RES_W-1:0] R2;
  logic             KB_Valid;
  logic [KB_W-1:0]  KB_Data;
  logic [RES_W-1:0] Bmp_Data;
  logic             Flush_Ack;
  logic             Copy_Ack;

  logic              Stall;
  logic [RES_W-1:0]  Result;
  logic              Result_We;
  logic [BMP_AW-1:0] Bmp_Addr;
  logic              Bmp_Rd;
  logic              Flush_Req;
  logic              Copy_Req;
  logic [RES_W-1:0]  Copy_Len;
  logic [RES_W-1:0]  Screen_Reg;
  logic              KB_Ovf;
  logic              Err;

  modport master (
    output Get_KB_in, Get_Bitmap, FrameFlush,
    output CopyToRAM, Cycles, Screen_opt, R2,
    output KB_Valid, KB_Data, Bmp_Data,
    output Flush_Ack, Copy_Ack,
    input  Stall, Result, Result_We,
    input  Bmp_Addr, Bmp_Rd, Flush_Req,
    input  Copy_Req, Copy_Len, Screen_Reg,
    input  KB_Ovf, Err
  );

  modport slave (
    input  Get_KB_in, Get_Bitmap, FrameFlush,
    input  CopyToRAM, Cycles, Screen_opt, R2,
    input  KB_Valid, KB_Data, Bmp_Data,
    input  Flush_Ack, Copy_Ack,
    output Stall, Result, Result_We,
    output Bmp_Addr, Bmp_Rd, Flush_Req,
    output Copy_Req, Copy_Len, Screen_Reg,
    output KB_Ovf, Err
  );

endinterface

// File: rtl/syscall_service_kb_fifo.sv
// Keyboard key-code FIFO with sticky overflow flag.
// A pop frees a slot in the same cycle, so push is then accepted.
module kb_fifo
  import syscall_service_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = KB_W
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic         o_ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         r_ovf;
  logic         w_full;
  logic         w_do_pop;
  logic         w_do_push;

  assign o_empty   = (r_wr == r_rd);
  assign w_full    = (r_wr[AW] != r_rd[AW]) &&
                     (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_head    = r_mem[r_rd[AW-1:0]];
  assign o_ovf     = r_ovf;

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      if (i_pop)
        r_ovf <= 1'b0;
      else if (i_push & w_full)
        r_ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/syscall_service.sv
// Syscall service responder: FSM, cycle counter, optional watchdog.
// Define SYSCALL_TIMEOUT_EN to enable the ack watchdog and Err flag.
module syscall_service
  import syscall_service_pkg::*;
#(
  parameter int KB_DEPTH    = 8,
  parameter int BMP_AW      = 10,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic         CLK,
  input logic         RST_N,
  syscall_service_if.slave bus
);

  if (KB_DEPTH < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("syscall_service: bad parameters");
  end

  logic [2:0]        r_state;
  logic [RES_W-1:0]  r_cnt;
  logic [RES_W-1:0]  r_res;
  logic [RES_W-1:0]  r_len;
  logic [RES_W-1:0]  r_scr;
  logic [BMP_AW-1:0] r_addr;
  logic              r_we;
  logic              r_rd;

  svc_e              w_svc;
  logic              w_idle;
  logic              w_busy;
  logic              w_wf;
  logic              w_wc;
  logic              w_to;
  logic              w_pop;
  logic              w_empty;
  logic [KB_W-1:0]   w_head;

  assign w_svc  = svc_pick(bus.FrameFlush, bus.CopyToRAM,
                           bus.Get_Bitmap, bus.Get_KB_in,
                           bus.Cycles, bus.Screen_opt);
  assign w_idle = (r_state == S_IDLE);
  assign w_busy = ~w_idle & (r_state != S_DONE);
  assign w_wf   = (r_state == S_WAIT_FLUSH);
  assign w_wc   = (r_state == S_WAIT_COPY);
  assign w_pop  = w_idle & (w_svc == SV_KB);

  kb_fifo #(
    .DEPTH (KB_DEPTH),
    .W     (KB_W)
  ) u_kb (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_push  (bus.KB_Valid),
    .i_din   (bus.KB_Data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_ovf   (bus.KB_Ovf)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_cnt <= '0;
    else        r_cnt <= r_cnt + 1'b1;
  end

`ifdef SYSCALL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] r_wd;
  logic            r_err;

  assign w_to = ((w_wf & ~bus.Flush_Ack) |
                 (w_wc & ~bus.Copy_Ack)) &
                (r_wd == WD_LAST);
  assign bus.Err = r_err;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_wf | w_wc) r_wd <= r_wd + 1'b1;
      else             r_wd <= '0;
      if (w_to) r_err <= 1'b1;
    end
  end
`else
  assign w_to    = 1'b0;
  assign bus.Err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_res   <= '0;
      r_len   <= '0;
      r_scr   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_rd    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          unique case (w_svc)
            SV_FLUSH: begin
              r_we    <= 1'b0;
              r_state <= bus.Flush_Ack ? S_DONE : S_WAIT_FLUSH;
            end
            SV_COPY: begin
              r_we    <= 1'b0;
              r_len   <= bus.R2;
              r_state <= bus.Copy_Ack ? S_DONE : S_WAIT_COPY;
            end
            SV_BMP: begin
              r_we    <= 1'b1;
              r_rd    <= 1'b1;
              r_addr  <= bus.R2[BMP_AW-1:0];
              r_state <= S_RD_BMP;
            end
            SV_KB: begin
              r_we    <= 1'b1;
              r_res   <= w_empty ? '0 : {{(RES_W-KB_W){1'b0}}, w_head};
              r_state <= S_DONE;
            end
            SV_CYC: begin
              r_we    <= 1'b1;
              r_res   <= r_cnt;
              r_state <= S_DONE;
            end
            SV_SCR:  r_scr <= bus.R2;
            SV_NONE: ;
          endcase
        end
        S_RD_BMP: begin
          r_rd    <= 1'b0;
          r_res   <= bus.Bmp_Data;
          r_state <= S_DONE;
        end
        S_WAIT_FLUSH:
          if (bus.Flush_Ack | w_to) r_state <= S_DONE;
        S_WAIT_COPY:
          if (bus.Copy_Ack | w_to) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // requests rise with the accepting strobe so an ack may arrive at once
  assign bus.Stall = RST_N & (w_busy |
                     (w_idle & (w_svc != SV_NONE) & (w_svc != SV_SCR)));
  assign bus.Flush_Req = RST_N &
                         (w_wf | (w_idle & (w_svc == SV_FLUSH)));
  assign bus.Copy_Req  = RST_N &
                         (w_wc | (w_idle & (w_svc == SV_COPY)));
  assign bus.Copy_Len  = (w_idle & (w_svc == SV_COPY)) ? bus.R2 : r_len;
  assign bus.Result     = r_res;
  assign bus.Result_We  = (r_state == S_DONE) & r_we;
  assign bus.Bmp_Addr   = r_addr;
  assign bus.Bmp_Rd     = r_rd;
  assign bus.Screen_Reg = r_scr;

endmodule

// File: tb/tb_syscall_service.sv
// Self-checking bench for syscall_service: directed table,
// hand sequences and randomized services against a queue model.
module tb_syscall_service;

  localparam int TO = 1024;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  syscall_service_if #(.BMP_AW(10)) bus ();

  syscall_service #(
    .KB_DEPTH    (8),
    .BMP_AW      (10),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [31:0] rom [0:1023];
  assign bus.Bmp_Data = rom[bus.Bmp_Addr];

  int total = 0;
  int bad   = 0;

  logic [7:0]  q[$];
  bit          m_ovf;
  bit          m_err;
  logic [31:0] m_scr;
  logic [31:0] m_cyc;

  always @(posedge CLK or negedge RST_N)
    if (!RST_N) m_cyc <= '0;
    else        m_cyc <= m_cyc + 1;

  int          n_stall, n_req, n_rd;
  logic [31:0] g_res;
  logic        g_we;

  typedef struct {
    logic [5:0]  m;
    logic [31:0] r2;
    int          ackd;
    logic [31:0] res;
    bit          we;
    int          st;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_strobes(input logic [5:0] m);
    bus.FrameFlush = m[5];
    bus.CopyToRAM  = m[4];
    bus.Get_Bitmap = m[3];
    bus.Get_KB_in  = m[2];
    bus.Cycles     = m[1];
    bus.Screen_opt = m[0];
  endtask

  task automatic svc(input logic [5:0] m, input logic [31:0] r2,
                     input int ackd, input bit pk, input logic [7:0] k);
    n_stall = 0; n_req = 0; n_rd = 0;
    set_strobes(m);
    bus.R2 = r2;
    bus.KB_Valid = pk;
    bus.KB_Data = k;
    for (int i = 0; i < 2000; i++) begin
      bus.Flush_Ack = (i == ackd);
      bus.Copy_Ack  = (i == ackd);
      #1;
      if (!bus.Stall) break;
      n_stall++;
      if (bus.Flush_Req | bus.Copy_Req) n_req++;
      if (bus.Bmp_Rd) n_rd++;
      @(negedge CLK);
      bus.KB_Valid = 1'b0;
    end
    chk("no_hang", bus.Stall, 0);
    g_res = bus.Result;
    g_we  = bus.Result_We;
    @(negedge CLK);
    set_strobes(6'b0);
    bus.KB_Valid  = 1'b0;
    bus.Flush_Ack = 1'b0;
    bus.Copy_Ack  = 1'b0;
  endtask

  task automatic push(input logic [7:0] k);
    if (q.size() < 8) q.push_back(k);
    else              m_ovf = 1'b1;
    bus.KB_Valid = 1'b1;
    bus.KB_Data  = k;
    @(negedge CLK);
    bus.KB_Valid = 1'b0;
  endtask

  task automatic run(input logic [5:0] m, input logic [31:0] r2,
                     input int ackd, input bit pk, input logic [7:0] k);
    logic [31:0] e_res;
    logic [9:0]  a;
    bit          e_we, kbw;
    int          e_st, e_req, e_rd;
    e_res = '0; e_we = 0; e_st = 0; e_req = 0; e_rd = 0;
    a = r2[9:0];
    kbw = (m[5:3] == 3'b000) && m[2];
    if (m[5] || m[4]) begin
      e_st  = (ackd < 0) ? TO + 1 : ackd + 1;
      e_req = e_st;
      if (ackd < 0) m_err = 1'b1;
    end else if (m[3]) begin
      e_st = 2; e_we = 1; e_rd = 1; e_res = rom[a];
    end else if (m[2]) begin
      e_st = 1; e_we = 1; m_ovf = 1'b0;
      if (q.size() > 0) e_res = {24'h0, q.pop_front()};
    end else if (m[1]) begin
      e_st = 1; e_we = 1; e_res = m_cyc;
    end else if (m[0]) begin
      m_scr = r2;
    end
    if (pk) begin
      if (kbw || q.size() < 8) q.push_back(k);
      else                     m_ovf = 1'b1;
    end
    svc(m, r2, ackd, pk, k);
    chk("stall_cycles", n_stall, e_st);
    chk("result_we", g_we, e_we);
    if (e_we) chk("result", g_res, e_res);
    chk("req_cycles", n_req, e_req);
    chk("bmp_rd_cycles", n_rd, e_rd);
    if (m[5:4] == 2'b01) chk("copy_len", bus.Copy_Len, r2);
    if (m[5:3] == 3'b001) chk("bmp_addr", bus.Bmp_Addr, a);
    chk("screen_reg", bus.Screen_Reg, m_scr);
    chk("kb_ovf", bus.KB_Ovf, m_ovf);
    chk("err", bus.Err, m_err);
  endtask

  initial begin
    set_strobes(6'b0);
    bus.R2 = '0; bus.KB_Valid = 0; bus.KB_Data = '0;
    bus.Flush_Ack = 0; bus.Copy_Ack = 0;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[10'h25] = 32'hDEADBEEF;
    m_ovf = 0; m_err = 0; m_scr = '0;

    tbl[0] = '{6'b001000, 32'h25, 0, 32'hDEADBEEF, 1, 2};
    tbl[1] = '{6'b100000, 32'h0, 5, 32'h0, 0, 6};
    tbl[2] = '{6'b100000, 32'h0, 0, 32'h0, 0, 1};
    tbl[3] = '{6'b010000, 32'h40, 3, 32'h0, 0, 4};
    tbl[4] = '{6'b000001, 32'hA5A50001, 0, 32'h0, 0, 0};
    tbl[5] = '{6'b101010, 32'h25, 2, 32'h0, 0, 3};
    tbl[6] = '{6'b011111, 32'h7, 1, 32'h0, 0, 2};
    tbl[7] = '{6'b001111, 32'h25, 0, 32'hDEADBEEF, 1, 2};

    set_strobes(6'b100100);
    #1;
    chk("rst_stall", bus.Stall, 0);
    chk("rst_flush_req", bus.Flush_Req, 0);
    chk("rst_result", bus.Result, 0);
    chk("rst_we", bus.Result_We, 0);
    chk("rst_ovf", bus.KB_Ovf, 0);
    chk("rst_err", bus.Err, 0);
    chk("rst_screen", bus.Screen_Reg, 0);
    chk("rst_bmp_rd", bus.Bmp_Rd, 0);
    repeat (3) @(negedge CLK);
    set_strobes(6'b0);
    RST_N = 1'b1;

    for (int i = 0; i < 100 && m_cyc != 32'h10; i++) @(negedge CLK);
    run(6'b000010, 32'h0, 0, 0, 8'h0);
    chk("cycles_0x10", g_res, 32'h10);

    push(8'h1C);
    push(8'h32);
    run(6'b000100, 32'h0, 0, 0, 8'h0);
    chk("kb_first", g_res, 32'h1C);
    run(6'b000100, 32'h0, 0, 0, 8'h0);
    chk("kb_second", g_res, 32'h32);
    run(6'b000100, 32'h0, 0, 0, 8'h0);
    chk("kb_empty", g_res, 32'h0);

    for (int i = 0; i < 8; i++) begin
      run(tbl[i].m, tbl[i].r2, tbl[i].ackd, 0, 8'h0);
      chk("tbl_stall", n_stall, tbl[i].st);
      chk("tbl_we", g_we, tbl[i].we);
      if (tbl[i].we) chk("tbl_result", g_res, tbl[i].res);
    end
    chk("tbl_screen", bus.Screen_Reg, 32'hA5A50001);

    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    chk("fill_no_ovf", bus.KB_Ovf, 0);
    push(8'h99);
    chk("fill_ovf", bus.KB_Ovf, 1);
    run(6'b000100, 32'h0, 0, 1, 8'h77);
    chk("popush_head", g_res, 32'h40);
    chk("popush_ovf", bus.KB_Ovf, 0);
    for (int i = 0; i < 8; i++) run(6'b000100, 32'h0, 0, 0, 8'h0);
    chk("popush_last", g_res, 32'h77);
    run(6'b000100, 32'h0, 0, 0, 8'h0);
    chk("drained", g_res, 32'h0);

    for (int it = 0; it < 60; it++) begin
      int np;
      np = $urandom_range(0, 2);
      for (int j = 0; j < np; j++) push(8'($urandom));
      run(6'($urandom_range(1, 63)), $urandom,
          $urandom_range(0, 6), ($urandom_range(0, 3) == 0),
          8'($urandom));
    end

`ifdef SYSCALL_TIMEOUT_EN
    run(6'b010000, 32'h55, -1, 0, 8'h0);
    chk("timeout_err", bus.Err, 1);
`endif

    bus.CopyToRAM = 1'b1;
    bus.R2 = 32'h123;
    repeat (10) @(negedge CLK);
    #1;
    chk("wait_copy_req", bus.Copy_Req, 1);
    chk("wait_stall", bus.Stall, 1);
    RST_N = 1'b0;
    #1;
    chk("midrst_copy_req", bus.Copy_Req, 0);
    chk("midrst_stall", bus.Stall, 0);
    chk("midrst_err", bus.Err, 0);
    bus.CopyToRAM = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    q.delete();
    m_ovf = 0; m_err = 0; m_scr = '0;
    #1;
    chk("post_rst_req", bus.Copy_Req, 0);
    chk("post_rst_stall", bus.Stall, 0);
    run(6'b000010, 32'h0, 0, 0, 8'h0);
    run(6'b000100, 32'h0, 0, 0, 8'h0);
    chk("post_rst_fifo", g_res, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
